// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Drives the register file's single write port (ad3/we3/wd3) from two
//   producers: the single-cycle ALU result path and the multi-cycle memory
//   result path. Memory results wait in a small in-order FIFO. The FIFO
//   drains whenever the ALU does not own the port. An ALU write kills any
//   older buffered result aimed at the same register. A combinational
//   lookup exposes values that are pending but not yet committed.
//
// Ports
//   clk_i, rst_n_i                 clock; asynchronous active-low reset
//   alu_valid_i/alu_rd_i/alu_data_i  ALU result (no backpressure)
//   mem_valid_i/mem_rd_i/mem_data_i  memory result offer
//   mem_ready_o                    buffer has a free slot
//   q_rd_i, fwd_hit_o, fwd_data_o  forwarding query and answer
//   drain_req_o                    buffer full; upstream must hold ALU writes
//   we3_o, ad3_o, wd3_o            registered regfile write port
module wb_write_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     alu_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0]    alu_data_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd_i,
  input  logic [DATA_WIDTH-1:0]    mem_data_i,
  input  logic [ADDRESS_WIDTH-1:0] q_rd_i,
  output logic                     fwd_hit_o,
  output logic [DATA_WIDTH-1:0]    fwd_data_o,
  output logic                     drain_req_o,
  output logic                     we3_o,
  output logic [ADDRESS_WIDTH-1:0] ad3_o,
  output logic [DATA_WIDTH-1:0]    wd3_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t FULL = cnt_t'(DEPTH);

  // A slot's valid bit is set only while it is occupied and not killed.
  // A killed slot still occupies the FIFO until it is popped.
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [ADDRESS_WIDTH-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  ptr_t                     head_q, head_d, tail_q, tail_d;
  cnt_t                     count_q, count_d;

  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;

  logic push, pop;
  ptr_t fwd_idx;

  // Ready comes from registered state only, so a pop in this cycle does not
  // open a slot until the next cycle.
  assign mem_ready_o = (count_q < FULL);
  assign drain_req_o = (count_q == FULL);
  // Results for r0 are accepted but never stored.
  assign push        = mem_valid_i && mem_ready_o && (mem_rd_i != '0);
  assign pop         = !alu_valid_i && (count_q != '0);

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we3_d   = 1'b0;
    ad3_d   = ad3_q;
    wd3_d   = wd3_q;

    if (alu_valid_i) begin
      if (alu_rd_i != '0) begin
        we3_d = 1'b1;
        ad3_d = alu_rd_i;
        wd3_d = alu_data_i;
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_q[i] == alu_rd_i) valid_d[i] = 1'b0;
        end
      end
    end else if (pop) begin
      if (valid_q[head_q]) begin
        we3_d = 1'b1;
        ad3_d = rd_q[head_q];
        wd3_d = data_q[head_q];
      end
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ptr_t'(1);
    end

    // A same-cycle memory result is older than the ALU write to the same
    // register, so it is stored already dead.
    if (push) begin
      valid_d[tail_q] = !(alu_valid_i && (alu_rd_i == mem_rd_i));
      tail_d          = tail_q + ptr_t'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so that the youngest matching entry wins. The
  // output register is older than anything still buffered.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_idx    = head_q;
    if (q_rd_i != '0) begin
      if (we3_q && (ad3_q == q_rd_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = wd3_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = head_q + ptr_t'(i);
        if (valid_q[fwd_idx] && (rd_q[fwd_idx] == q_rd_i)) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = data_q[fwd_idx];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we3_q   <= 1'b0;
      ad3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we3_q   <= we3_d;
      ad3_q   <= ad3_d;
      wd3_q   <= wd3_d;
    end
  end

  // Payload storage needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_q[tail_q]   <= mem_rd_i;
      data_q[tail_q] <= mem_data_i;
    end
  end

  assign we3_o = we3_q;
  assign ad3_o = ad3_q;
  assign wd3_o = wd3_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, mem_ready, fwd_hit, drain_req, we3;
  logic [4:0]  alu_rd, mem_rd, q_rd, ad3;
  logic [31:0] alu_data, mem_data, fwd_data, wd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready),
    .mem_rd_i(mem_rd), .mem_data_i(mem_data),
    .q_rd_i(q_rd), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
    .drain_req_o(drain_req),
    .we3_o(we3), .ad3_o(ad3), .wd3_o(wd3)
  );

  // Regfile as seen through the write port.
  logic [31:0] dut_rf [32];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) dut_rf[i] <= '0;
    end else if (we3) begin
      dut_rf[ad3] <= wd3;
    end
  end

  // Upstream must not issue ALU writes while the buffer is full.
  always @(posedge clk) begin
    if (rst_n && alu_valid && drain_req) begin
      errors++;
      $display("FAIL protocol: alu_valid=1 while drain_req=1 at %0t", $time);
    end
  end

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        mv;  logic [4:0] mrd; logic [31:0] mdat;
    logic [4:0]  q;
    logic        rdy; logic drn; logic we; logic [4:0] ad; logic [31:0] wd;
    logic        hit; logic [31:0] fd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                     input logic [4:0] q,
                     input logic rdy, input logic drn, input logic we,
                     input logic [4:0] ad, input logic [31:0] wd,
                     input logic hit, input logic [31:0] fd);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat; v.q = q;
    v.rdy = rdy; v.drn = drn; v.we = we; v.ad = ad; v.wd = wd;
    v.hit = hit; v.fd = fd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic [4:0] q);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat; q_rd = q;
  endtask

  logic [31:0] ref_rf [8];
  int          n_wr;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    //  av ard adat          mv mrd mdat     q     rdy drn we ad  wd            hit fd
    add(0, 0,  32'h0,        0, 0,  32'h0,   0,    1,  0,  0, 0,  32'h0,        0, 32'h0);
    add(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,   0,    1,  0,  0, 0,  32'h0,        0, 32'h0);
    add(1, 0,  32'h1234,     0, 0,  32'h0,   5,    1,  0,  1, 5,  32'hDEADBEEF, 1, 32'hDEADBEEF);
    add(0, 0,  32'h0,        0, 0,  32'h0,   5,    1,  0,  0, 5,  32'hDEADBEEF, 0, 32'h0);
    add(1, 1,  32'h100,      1, 3,  32'h11,  3,    1,  0,  0, 5,  32'hDEADBEEF, 0, 32'h0);
    add(1, 2,  32'h200,      0, 0,  32'h0,   3,    1,  0,  1, 1,  32'h100,      1, 32'h11);
    add(1, 1,  32'h300,      1, 6,  32'h66,  6,    1,  0,  1, 2,  32'h200,      0, 32'h0);
    add(0, 0,  32'h0,        1, 9,  32'h99,  6,    0,  1,  1, 1,  32'h300,      1, 32'h66);
    add(0, 0,  32'h0,        1, 9,  32'h99,  3,    1,  0,  1, 3,  32'h11,       1, 32'h11);
    add(0, 0,  32'h0,        0, 0,  32'h0,   9,    1,  0,  1, 6,  32'h66,       1, 32'h99);
    add(0, 0,  32'h0,        0, 0,  32'h0,   9,    1,  0,  1, 9,  32'h99,       1, 32'h99);
    add(0, 0,  32'h0,        0, 0,  32'h0,   9,    1,  0,  0, 9,  32'h99,       0, 32'h0);
    add(0, 0,  32'h0,        1, 7,  32'hAA,  7,    1,  0,  0, 9,  32'h99,       0, 32'h0);
    add(1, 7,  32'hBB,       0, 0,  32'h0,   7,    1,  0,  0, 9,  32'h99,       1, 32'hAA);
    add(0, 0,  32'h0,        0, 0,  32'h0,   7,    1,  0,  1, 7,  32'hBB,       1, 32'hBB);
    add(0, 0,  32'h0,        0, 0,  32'h0,   7,    1,  0,  0, 7,  32'hBB,       0, 32'h0);
    add(1, 7,  32'hCC,       1, 7,  32'hDD,  7,    1,  0,  0, 7,  32'hBB,       0, 32'h0);
    add(0, 0,  32'h0,        0, 0,  32'h0,   7,    1,  0,  1, 7,  32'hCC,       1, 32'hCC);
    add(0, 0,  32'h0,        0, 0,  32'h0,   7,    1,  0,  0, 7,  32'hCC,       0, 32'h0);
    add(0, 0,  32'h0,        1, 4,  32'h10,  4,    1,  0,  0, 7,  32'hCC,       0, 32'h0);
    add(1, 8,  32'h80,       1, 4,  32'h20,  4,    1,  0,  0, 7,  32'hCC,       1, 32'h10);
    add(0, 0,  32'h0,        0, 0,  32'h0,   4,    0,  1,  1, 8,  32'h80,       1, 32'h20);
    add(0, 0,  32'h0,        0, 0,  32'h0,   4,    1,  0,  1, 4,  32'h10,       1, 32'h20);
    add(0, 0,  32'h0,        0, 0,  32'h0,   4,    1,  0,  1, 4,  32'h20,       1, 32'h20);
    add(0, 0,  32'h0,        0, 0,  32'h0,   4,    1,  0,  0, 4,  32'h20,       0, 32'h0);
    add(0, 0,  32'h0,        1, 0,  32'h55,  0,    1,  0,  0, 4,  32'h20,       0, 32'h0);
    add(0, 0,  32'h0,        0, 0,  32'h0,   0,    1,  0,  0, 4,  32'h20,       0, 32'h0);
    add(0, 0,  32'h0,        0, 0,  32'h0,   0,    1,  0,  0, 4,  32'h20,       0, 32'h0);
    add(0, 0,  32'h0,        1, 10, 32'hA0,  10,   1,  0,  0, 4,  32'h20,       0, 32'h0);
    add(0, 0,  32'h0,        0, 0,  32'h0,   10,   1,  0,  0, 4,  32'h20,       1, 32'hA0);
    add(0, 0,  32'h0,        0, 0,  32'h0,   10,   1,  0,  1, 10, 32'hA0,       1, 32'hA0);
    add(0, 0,  32'h0,        0, 0,  32'h0,   10,   1,  0,  0, 10, 32'hA0,       0, 32'h0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Inputs land on the falling edge; outputs are sampled 1 ns later, so
    // registered outputs reflect the previous row's issue decision.
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].av, tbl[k].ard, tbl[k].adat, tbl[k].mv, tbl[k].mrd, tbl[k].mdat, tbl[k].q);
      #1;
      chk($sformatf("row%0d mem_ready", k), 32'(mem_ready), 32'(tbl[k].rdy));
      chk($sformatf("row%0d drain_req", k), 32'(drain_req), 32'(tbl[k].drn));
      chk($sformatf("row%0d we3", k),       32'(we3),       32'(tbl[k].we));
      chk($sformatf("row%0d ad3", k),       32'(ad3),       32'(tbl[k].ad));
      chk($sformatf("row%0d wd3", k),       wd3,            tbl[k].wd);
      chk($sformatf("row%0d fwd_hit", k),   32'(fwd_hit),   32'(tbl[k].hit));
      chk($sformatf("row%0d fwd_data", k),  fwd_data,       tbl[k].fd);
    end

    // Reset mid-run with two entries buffered and a write in the output register.
    @(negedge clk); drive(1, 11, 32'hB1, 1, 12, 32'hC1, 0);
    @(negedge clk); drive(1, 11, 32'hB2, 1, 13, 32'hC2, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 12);
    #1;
    chk("pre-reset drain_req", 32'(drain_req), 32'd1);
    chk("pre-reset we3", 32'(we3), 32'd1);
    chk("pre-reset fwd_data", fwd_data, 32'hC1);
    rst_n = 1'b0;
    #1;
    chk("reset we3", 32'(we3), 32'd0);
    chk("reset ad3", 32'(ad3), 32'd0);
    chk("reset wd3", wd3, 32'd0);
    chk("reset mem_ready", 32'(mem_ready), 32'd1);
    chk("reset drain_req", 32'(drain_req), 32'd0);
    chk("reset fwd_hit", 32'(fwd_hit), 32'd0);
    chk("reset fwd_data", fwd_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("post-reset cyc%0d we3", c), 32'(we3), 32'd0);
      chk($sformatf("post-reset cyc%0d fwd_hit", c), 32'(fwd_hit), 32'd0);
    end

    // Random traffic against a program-order model: memory results accepted
    // in a cycle are older than that cycle's ALU write.
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    n_wr = 0;
    for (int c = 0; c < 2000 && n_wr < 100; c++) begin
      @(negedge clk);
      drive(!drain_req && ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
      #1;
      if (mem_valid && mem_ready) begin
        if (mem_rd != '0) ref_rf[mem_rd[2:0]] = mem_data;
        n_wr++;
      end
      if (alu_valid) begin
        if (alu_rd != '0) ref_rf[alu_rd[2:0]] = alu_data;
        n_wr++;
      end
    end
    checks++;
    if (n_wr < 100) begin
      errors++;
      $display("FAIL random budget: got %0d writes required 100", n_wr);
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("drained mem_ready", 32'(mem_ready), 32'd1);
    chk("drained we3", 32'(we3), 32'd0);
    for (int r = 1; r < 8; r++) begin
      chk($sformatf("regfile r%0d", r), dut_rf[r], ref_rf[r]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Writeback arbiter that drives the register file's single write port (AD3/WE3/WD3) from two producers: the single-cycle ALU result path and the multi-cycle memory/load result path. Memory results are held in a small in-order buffer and drained whenever the ALU does not own the port. Write-after-write ordering to the same register is enforced. A forwarding lookup exposes pending, not-yet-committed values to the operand-read stage.

## Interface
- ADDRESS_WIDTH, 5, register index width
- DATA_WIDTH, 32, data width
- DEPTH, 2, memory-result buffer entries (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  ADDRESS_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  memory result offered
- mem_ready  out  1  buffer can accept
- mem_rd  in  ADDRESS_WIDTH  memory destination register
- mem_data  in  DATA_WIDTH  memory result
- q_rd  in  ADDRESS_WIDTH  forwarding query register
- fwd_hit  out  1  q_rd has a pending value
- fwd_data  out  DATA_WIDTH  pending value for q_rd
- drain_req  out  1  buffer full; upstream must stop issuing ALU writes
- we3  out  1  regfile write enable (registered)
- ad3  out  ADDRESS_WIDTH  regfile write address (registered)
- wd3  out  DATA_WIDTH  regfile write data (registered)

## Operation
- Buffer is a circular FIFO of {valid, rd, data}, with head/tail pointers and a count of 0..DEPTH.
- mem_ready = (count < DEPTH), from registered state only. It does not depend on a same-cycle pop.
- Accept when mem_valid && mem_ready. If mem_rd == 0, the transaction is accepted and discarded (no entry is stored).
- Port arbitration, evaluated each cycle:
  - If alu_valid: issue the ALU write. The buffer does not pop.
  - Else if count > 0: pop the head. Issue its write only if its valid bit is set; a killed entry pops with no write.
  - Else: no write.
- A write with rd == 0 never asserts we3.
- WAW kill: when an ALU write issues, every buffered entry with rd == alu_rd has its valid bit cleared. A memory result accepted in the same cycle with mem_rd == alu_rd is treated as older and is stored already killed.
- Push and pop in the same cycle are legal: count is unchanged and both pointers advance.
- Forwarding, combinational, for q_rd != 0:
  - Search order is youngest valid buffered entry first, then the output register (we3 && ad3 == q_rd).
  - On the first match: fwd_hit = 1 and fwd_data = the matching value.
  - Otherwise fwd_hit = 0 and fwd_data = 0.
  - q_rd == 0 always gives fwd_hit = 0.
- drain_req = (count == DEPTH).
- If the upstream raises alu_valid while drain_req is high, the ALU still wins and no data is lost. This is a protocol violation; a bench assertion flags it.

## Timing
- Reset (rst_n low, asynchronous): count = 0, head = tail = 0, all valid bits = 0, we3 = 0, ad3 = 0, wd3 = 0. Resulting outputs: mem_ready = 1, drain_req = 0, fwd_hit = 0, fwd_data = 0.
- Reset mid-operation discards all buffered entries and any pending output write.
- ALU write latency: alu_valid at edge N produces we3/ad3/wd3 in the cycle after edge N. The regfile commits on edge N+1.
- Memory write latency:
  - Minimum 1 cycle: accepted at edge N with an empty buffer and no ALU write produces we3 after edge N+1. The entry must be stored first, so it is not popped in its accept cycle.
  - Otherwise the latency is bounded by ALU occupancy.
- mem_ready falls in the cycle after the buffer becomes full. It rises in the cycle after a pop that frees a slot.
- Once the buffer holds DEPTH entries, the earliest new acceptance is the cycle after the first pop.
- The output register updates every cycle. we3 = 0 in any cycle with no issued write; ad3/wd3 hold their previous values.

## Test plan
- Reset then idle: rst_n low mid-run with 2 entries buffered → we3 = 0, mem_ready = 1, drain_req = 0, and no writes after release.
- ALU only: alu_valid with rd = 5, data = 0xDEADBEEF → next cycle we3 = 1, ad3 = 5, wd3 = 0xDEADBEEF. rd = 0 → we3 stays 0.
- Arbitration: mem rd = 3, data = 0x11 accepted while ALU is busy for 3 cycles → mem write appears on the first ALU-idle cycle. Fill to DEPTH → mem_ready = 0 and drain_req = 1.
- WAW kill: buffer holds rd = 7, data = 0xAA; ALU writes rd = 7, data = 0xBB → regfile sees only 0xBB, and the killed pop gives a we3 = 0 cycle. Same-cycle mem and ALU to rd = 7 → only the ALU write commits.
- Forwarding: buffer holds rd = 4 = 0x10, then rd = 4 = 0x20 → q_rd = 4 gives hit with 0x20. After both drain, hit is sourced from the output register for one cycle, then 0.
- Push and pop same cycle at count = 1 → count stays 1, order preserved. 100 random mem/ALU writes compared against a reference regfile model.
